register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameters, one per line:
- REG_NUM, 32, architectural registers x0..x31
- ROB_SIZE, 16, reorder-buffer entries
- ROB_ID_W, 5, rename-tag width; tag = entry index + 1, tag 0 = "no pending producer"
- DATA_W, 32, register data width

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = hold all state
- rs1_from_dsp  in  5  source-1 register index
- rs2_from_dsp  in  5  source-2 register index
- V1_to_dsp  out  DATA_W  source-1 value
- Q1_to_dsp  out  ROB_ID_W  source-1 tag; 0 = value valid
- V2_to_dsp  out  DATA_W  source-2 value
- Q2_to_dsp  out  ROB_ID_W  source-2 tag; 0 = value valid
- ena_from_dsp  in  1  dispatch of an instruction that writes rd
- rd_from_dsp  in  5  dispatch destination register
- rob_id_from_dsp  in  ROB_ID_W  tag allocated to the dispatch
- commit_flag  in  1  ROB commit valid this cycle
- rd_from_rob  in  5  committing destination register
- Q_from_rob  in  ROB_ID_W  committing tag
- V_from_rob  in  DATA_W  committing value
- rollback_flag  in  1  commit-jump flush, coincident with that commit

Function
REQ-003 Each of x1..x31 SHALL hold a value and a tag; x0 SHALL read V=0, Q=0 in every state.
REQ-004 Read ports SHALL be combinational with zero-cycle latency.
REQ-005 Commit bypass: if commit_flag=1, rd_from_rob=rsN≠0, tag[rsN]≠0 and tag[rsN]=Q_from_rob, the read port SHALL return QN=0 and VN=V_from_rob.
REQ-006 Without bypass, each read port SHALL return the stored value and tag.
REQ-007 Dispatch does not bypass to reads in the same cycle; reads reflect the pre-dispatch tag.
REQ-008 Commit write (rdy=1, commit_flag=1, rd_from_rob≠0): value[rd] SHALL take V_from_rob at the next edge, whether or not the tags match.
REQ-009 Commit tag clear: tag[rd] SHALL become 0 only if tag[rd]=Q_from_rob and no same-cycle dispatch targets rd. Otherwise the tag is unchanged.
REQ-010 Dispatch (rdy=1, ena_from_dsp=1, rd_from_dsp≠0, rollback_flag=0): tag[rd] SHALL take rob_id_from_dsp at the next edge.
REQ-011 Dispatch and commit to the same rd in the same cycle: the dispatch tag wins; the commit value is still written.
REQ-012 Dispatch or commit with rd=0 SHALL have no effect.
REQ-013 Rollback (rdy=1, rollback_flag=1):
- all tags SHALL clear to 0;
- the coincident commit value write of REQ-008 SHALL still occur;
- any same-cycle dispatch SHALL be ignored.
REQ-014 rdy=0 SHALL freeze all state; reads remain combinational.

Reset
REQ-015 rst=1 at a clock edge SHALL zero all values and tags, with priority over rdy, commit, dispatch and rollback.
REQ-016 While rst=1, read ports SHALL return 0/0 after the first edge.
REQ-017 Reset mid-operation SHALL discard any pending commit or dispatch of that cycle.

Structure
REQ-018 REG_NUM, ROB_SIZE, ROB_ID_W, DATA_W, ZERO_ROB=0, ZERO_WORD=0 and the register-index width SHALL live in the shared defines package used by the reorder buffer and dispatcher.
REQ-019 The tag array with its dispatch, clear and rollback logic SHALL be one sub-module, reg_tag_table; value storage and the read/bypass muxes remain in register_file.

Verification
REQ-020 Reset, then read x5 and x0 -> V=0, Q=0 on both.
REQ-021 Dispatch rd=5, tag 3; next cycle commit rd=5, Q=3, V=0x1234 while reading rs1=5 -> same-cycle V1=0x1234, Q1=0; after the edge, value=0x1234, tag=0.
REQ-022 Dispatch rd=7, tag 2; then dispatch rd=7, tag 4; then commit rd=7, Q=2, V=0xAA -> value=0xAA, tag stays 4; a read returns Q=4.
REQ-023 Commit rd=9, Q=6, V=0x55 while dispatching rd=9, tag 8 (tag[9] was 6) -> value=0x55, tag=8.
REQ-024 Tags pending on x1, x2, x3; commit rd=1, V=0x100 with rollback_flag=1 and a dispatch rd=4, tag 5 -> x1 value=0x100, all tags 0, x4 tag 0.
REQ-025 Hold rdy=0 while driving commit rd=10, V=0xFF and dispatch rd=11 -> no state change; writes to x0 never alter 0/0.

Source files
------------

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared core widths, tag/word types and zero constants
package register_file_pkg;
    localparam int REG_NUM = 32;
    localparam int ROB_SIZE = 16;
    localparam int ROB_ID_W = 5;
    localparam int DATA_W = 32;
    localparam int REG_IDX_W = $clog2(REG_NUM);
    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [$clog2(ROB_SIZE)-1:0] rob_idx_t;
    localparam rob_id_t ZERO_ROB = '0;
    localparam word_t ZERO_WORD = '0;
    // Tag 0 is reserved for "no pending producer", so tags are entry index + 1.
    function automatic rob_id_t tag_of(rob_idx_t idx);
        return rob_id_t'(idx) + rob_id_t'(1);
    endfunction
endpackage

// File: rtl/register_file_if.sv
// register_file_if: dispatcher read/rename and reorder-buffer commit bus
interface register_file_if;
    import register_file_pkg::*;
    reg_idx_t rs1_from_dsp;
    reg_idx_t rs2_from_dsp;
    word_t V1_to_dsp;
    rob_id_t Q1_to_dsp;
    word_t V2_to_dsp;
    rob_id_t Q2_to_dsp;
    logic ena_from_dsp;
    reg_idx_t rd_from_dsp;
    rob_id_t rob_id_from_dsp;
    logic commit_flag;
    reg_idx_t rd_from_rob;
    rob_id_t Q_from_rob;
    word_t V_from_rob;
    logic rollback_flag;
    modport master (
        output rs1_from_dsp, rs2_from_dsp, ena_from_dsp, rd_from_dsp, rob_id_from_dsp,
        output commit_flag, rd_from_rob, Q_from_rob, V_from_rob, rollback_flag,
        input V1_to_dsp, Q1_to_dsp, V2_to_dsp, Q2_to_dsp
    );
    modport slave (
        input rs1_from_dsp, rs2_from_dsp, ena_from_dsp, rd_from_dsp, rob_id_from_dsp,
        input commit_flag, rd_from_rob, Q_from_rob, V_from_rob, rollback_flag,
        output V1_to_dsp, Q1_to_dsp, V2_to_dsp, Q2_to_dsp
    );
endinterface

// File: rtl/register_file_reg_tag_table.sv
// reg_tag_table: per-register rename tags with dispatch set, commit clear and rollback flush
module reg_tag_table
    import register_file_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     ena,
    input  reg_idx_t rd,
    input  rob_id_t  rob_id,
    input  logic     commit,
    input  reg_idx_t commit_rd,
    input  rob_id_t  commit_q,
    input  logic     rollback,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    output rob_id_t  q1,
    output rob_id_t  q2
);
    rob_id_t tags [REG_NUM];
    // A newer dispatch to the same register outranks clearing the older producer's tag.
    always_ff @(posedge clk)
        for (int i = 0; i < REG_NUM; i++)
            if (rst || i == 0) tags[i] <= ZERO_ROB;
            else if (rdy)
                tags[i] <= rollback ? ZERO_ROB :
                           ena && rd == reg_idx_t'(i) ? rob_id :
                           commit && commit_rd == reg_idx_t'(i) && tags[i] == commit_q ? ZERO_ROB :
                           tags[i];
    assign q1 = tags[rs1];
    assign q2 = tags[rs2];
endmodule

// File: rtl/register_file.sv
// register_file: architectural values with rename tags and commit-bypassed read ports
module register_file
    import register_file_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic rdy,
    register_file_if.slave bus
);
    word_t vals [REG_NUM];
    rob_id_t t1, t2;
    logic byp1, byp2;
    reg_tag_table u_tags (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .ena(bus.ena_from_dsp),
        .rd(bus.rd_from_dsp),
        .rob_id(bus.rob_id_from_dsp),
        .commit(bus.commit_flag),
        .commit_rd(bus.rd_from_rob),
        .commit_q(bus.Q_from_rob),
        .rollback(bus.rollback_flag),
        .rs1(bus.rs1_from_dsp),
        .rs2(bus.rs2_from_dsp),
        .q1(t1),
        .q2(t2)
    );
    always_ff @(posedge clk)
        for (int i = 0; i < REG_NUM; i++)
            if (rst || i == 0) vals[i] <= ZERO_WORD;
            else if (rdy && bus.commit_flag && bus.rd_from_rob == reg_idx_t'(i)) vals[i] <= bus.V_from_rob;
    // Forward only when the committing tag is the one the register is still waiting on.
    assign byp1 = bus.commit_flag && bus.rd_from_rob == bus.rs1_from_dsp && t1 != ZERO_ROB && t1 == bus.Q_from_rob;
    assign byp2 = bus.commit_flag && bus.rd_from_rob == bus.rs2_from_dsp && t2 != ZERO_ROB && t2 == bus.Q_from_rob;
    assign bus.V1_to_dsp = bus.rs1_from_dsp == '0 ? ZERO_WORD : byp1 ? bus.V_from_rob : vals[bus.rs1_from_dsp];
    assign bus.Q1_to_dsp = bus.rs1_from_dsp == '0 || byp1 ? ZERO_ROB : t1;
    assign bus.V2_to_dsp = bus.rs2_from_dsp == '0 ? ZERO_WORD : byp2 ? bus.V_from_rob : vals[bus.rs2_from_dsp];
    assign bus.Q2_to_dsp = bus.rs2_from_dsp == '0 || byp2 ? ZERO_ROB : t2;
endmodule
